// File: rtl/three_wire_pkg.sv
// Shared types and frame constants for the three-wire serial bus master.
package three_wire_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StTurn,
    StData,
    StHold
  } tw_state_e;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 16;

  localparam int unsigned CMD_BITS  = 1 + ADDR_W_DEF;
  localparam int unsigned DATA_BITS = DATA_W_DEF;
  localparam int unsigned TURN_HALF = 2;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/three_wire_clkgen.sv
// Serial-clock generator: divides clk_i into half-period ticks and toggles sclk.
module three_wire_clkgen
  import three_wire_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic toggle_en_i,
  output logic sclk_o,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  logic [CntW-1:0] cnt_q;
  logic            sclk_q;

  assign tick_o = en_i && (cnt_q == CntW'(CLK_DIV - 1));
  assign rise_o = tick_o && toggle_en_i && !sclk_q;
  assign fall_o = tick_o && toggle_en_i && sclk_q;
  assign sclk_o = sclk_q;

  // Counter and sclk are held cleared whenever the master is idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
      if (tick_o && toggle_en_i) begin
        sclk_q <= ~sclk_q;
      end
    end
  end

endmodule

// File: rtl/three_wire.sv
// Three-wire serial bus master (sclk, active-low cs, bidirectional data).
// Define THREE_WIRE_LSB_FIRST_EN to shift address and data fields LSB-first.
module three_wire
  import three_wire_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_r_w,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wr_data,
  input  logic              in_start,
  output logic [DATA_W-1:0] out_rd_data,
  output logic              out_io_in_progress,
  output logic              out_tw_clock,
  output logic              out_tw_cs,
  inout  wire               io_tw_data
);

  localparam int unsigned CmdLen   = 1 + ADDR_W;
  localparam int unsigned FrameLen = CmdLen + DATA_W;
  localparam int unsigned CntW     = $clog2(max_u(max_u(CmdLen, DATA_W), TURN_HALF));

  tw_state_e           state_q, state_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FrameLen-1:0] tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d, rx_shift;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                r_w_q, r_w_d;
  logic                start_q1, start_q2, start_edge;
  logic [ADDR_W-1:0]   addr_ord;
  logic [DATA_W-1:0]   data_ord;
  logic                clk_en, toggle_en, sclk, tick, rise, fall, drive;

  assign start_edge = start_q1 && !start_q2;

`ifdef THREE_WIRE_LSB_FIRST_EN
  always_comb begin
    addr_ord = '0;
    data_ord = '0;
    for (int i = 0; i < int'(ADDR_W); i++) addr_ord[i] = in_addr[ADDR_W-1-i];
    for (int i = 0; i < int'(DATA_W); i++) data_ord[i] = in_wr_data[DATA_W-1-i];
  end
  assign rx_shift = {io_tw_data, rx_q[DATA_W-1:1]};
`else
  assign addr_ord = in_addr;
  assign data_ord = in_wr_data;
  assign rx_shift = {rx_q[DATA_W-2:0], io_tw_data};
`endif

  assign clk_en    = (state_q != StIdle);
  assign toggle_en = (state_q == StCmd) || (state_q == StTurn) || (state_q == StData);

  three_wire_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk_i      (in_clk),
    .rst_i      (in_rst),
    .en_i       (clk_en),
    .toggle_en_i(toggle_en),
    .sclk_o     (sclk),
    .tick_o     (tick),
    .rise_o     (rise),
    .fall_o     (fall)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    r_w_d     = r_w_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d   = StCmd;
          r_w_d     = in_r_w;
          tx_d      = {in_r_w, addr_ord, data_ord};
          bit_cnt_d = '0;
        end
      end
      // Each bit ends on the sclk fall, so the line only changes with sclk low.
      StCmd: begin
        if (fall) begin
          tx_d = tx_q << 1;
          if (bit_cnt_q == CntW'(CmdLen - 1)) begin
            bit_cnt_d = '0;
            state_d   = (r_w_q == RD) ? StTurn : StData;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StTurn: begin
        if (tick) begin
          if (bit_cnt_q == CntW'(TURN_HALF - 1)) begin
            bit_cnt_d = '0;
            state_d   = StData;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (rise && (r_w_q == RD)) begin
          rx_d = rx_shift;
        end
        if (fall) begin
          tx_d = tx_q << 1;
          if (bit_cnt_q == CntW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = StHold;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (tick) begin
          state_d = StIdle;
          if (r_w_q == RD) begin
            rd_data_d = rx_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      r_w_q     <= WR;
      start_q1  <= 1'b0;
      start_q2  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      r_w_q     <= r_w_d;
      start_q1  <= in_start;
      start_q2  <= start_q1;
    end
  end

  assign drive              = (state_q == StCmd) || ((state_q == StData) && (r_w_q == WR));
  assign io_tw_data         = drive ? tx_q[FrameLen-1] : 1'bz;
  assign out_tw_cs          = (state_q == StIdle);
  assign out_io_in_progress = (state_q != StIdle);
  assign out_tw_clock       = sclk;
  assign out_rd_data        = rd_data_q;

endmodule

// File: tb/tb_three_wire.sv
// Randomised self-checking bench for three_wire with a serial slave model.
module tb_three_wire;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 16;

  logic              in_clk = 1'b0;
  logic              in_rst = 1'b1;
  logic              in_r_w = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_wr_data = '0;
  logic              in_start = 1'b0;
  wire  [DATA_W-1:0] out_rd_data;
  wire               out_io_in_progress;
  wire               out_tw_clock;
  wire               out_tw_cs;
  wire               io_tw_data;

  pullup (io_tw_data);

  three_wire #(
    .CLK_DIV(CLK_DIV),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .in_clk            (in_clk),
    .in_rst            (in_rst),
    .in_r_w            (in_r_w),
    .in_addr           (in_addr),
    .in_wr_data        (in_wr_data),
    .in_start          (in_start),
    .out_rd_data       (out_rd_data),
    .out_io_in_progress(out_io_in_progress),
    .out_tw_clock      (out_tw_clock),
    .out_tw_cs         (out_tw_cs),
    .io_tw_data        (io_tw_data)
  );

  always #5 in_clk = ~in_clk;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [DATA_W-1:0] exp_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serial slave: records every bit seen on sclk rise, answers reads during DATA.
  logic              slave_oe = 1'b0;
  logic              slave_bit = 1'b0;
  logic              slave_rd = 1'b0;
  logic [DATA_W-1:0] slave_resp = '0;
  logic              bits_q[$];
  int                cs_falls = 0;
  int                rise_frame = -1;
  int                fall_frame = -1;
  int                s_falls = 0;

  assign io_tw_data = slave_oe ? slave_bit : 1'bz;

  always @(negedge out_tw_cs) cs_falls++;

  always @(posedge out_tw_clock) begin
    if (!out_tw_cs) begin
      if (rise_frame != cs_falls) begin
        rise_frame = cs_falls;
        slave_rd   = io_tw_data;
      end
      bits_q.push_back(io_tw_data);
    end
  end

  // Falls 1..10 end the command, 11 ends turnaround, 11..26 launch data bits.
  always @(negedge out_tw_clock or posedge out_tw_cs) begin
    if (out_tw_cs) begin
      slave_oe <= 1'b0;
    end else begin
      if (fall_frame != cs_falls) begin
        fall_frame = cs_falls;
        s_falls    = 0;
      end
      s_falls++;
      if (slave_rd && s_falls >= 11 && s_falls <= 26) begin
        slave_oe <= 1'b1;
`ifdef THREE_WIRE_LSB_FIRST_EN
        slave_bit <= slave_resp[s_falls - 11];
`else
        slave_bit <= slave_resp[DATA_W - 1 - (s_falls - 11)];
`endif
      end else begin
        slave_oe <= 1'b0;
      end
    end
  end

  function automatic logic [25:0] frame_bits(input logic rw, input logic [8:0] a,
                                             input logic [15:0] d);
    logic [8:0]  ao;
    logic [15:0] dorder;
    ao     = a;
    dorder = d;
`ifdef THREE_WIRE_LSB_FIRST_EN
    for (int i = 0; i < 9; i++) ao[i] = a[8 - i];
    for (int i = 0; i < 16; i++) dorder[i] = d[15 - i];
`endif
    return {rw, ao, dorder};
  endfunction

  task automatic run_frame(input string name, input logic rw, input logic [8:0] a,
                           input logic [15:0] wd, input logic [15:0] resp, input int hold,
                           input bit mid, input int gap);
    int          base, busy_len, t, my_falls, rel_viol, cs_viol, exp_len, n;
    logic        started, prev_sclk;
    logic [25:0] got, exp;
    busy_len = 0; t = 0; my_falls = 0; rel_viol = 0; cs_viol = 0;
    started = 1'b0; prev_sclk = 1'b0; got = '0;
    repeat (gap) @(negedge in_clk);
    check({name, "_idle"}, {29'd0, out_io_in_progress, out_tw_cs, out_tw_clock}, 32'b010);
    check({name, "_nframes"}, cs_falls, frames);
    in_r_w = rw; in_addr = a; in_wr_data = wd; slave_resp = resp;
    base = bits_q.size();
    in_start = 1'b1;
    while (1) begin
      @(negedge in_clk);
      t++;
      if (t == hold) in_start = 1'b0;
      if (out_io_in_progress) begin
        started = 1'b1;
        busy_len++;
        if (out_tw_cs !== 1'b0) cs_viol++;
        if (prev_sclk && !out_tw_clock) my_falls++;
        if (rw && my_falls >= 10 && !slave_oe && io_tw_data !== 1'b1) rel_viol++;
        if (busy_len == 50) begin
          in_r_w = ~rw; in_addr = 9'($urandom); in_wr_data = 16'($urandom);
        end
        if (mid && busy_len == 100) in_start = 1'b1;
        if (mid && busy_len == 104) in_start = 1'b0;
      end else if (started) begin
        break;
      end
      prev_sclk = out_tw_clock;
      if (t > 2000) break;
    end
    frames++;
    exp_len = CLK_DIV * (2 * (1 + ADDR_W + DATA_W) + 1) + (rw ? 2 * CLK_DIV : 0);
    if (rw) exp_rd = resp;
    check({name, "_rd_data"}, out_rd_data, exp_rd);
    check({name, "_busy_len"}, busy_len, exp_len);
    check({name, "_cs_end"}, out_tw_cs, 1'b1);
    check({name, "_cs_low"}, cs_viol, 0);
    n = bits_q.size() - base;
    check({name, "_nbits"}, n, rw ? 27 : 26);
    for (int i = 0; i < 26; i++) if (i < n) got[25 - i] = bits_q[base + i];
    exp = frame_bits(rw, a, wd);
    if (rw) begin
      check({name, "_cmd_bits"}, got[25:16], exp[25:16]);
      check({name, "_turn_released"}, got[15], 1'b1);
      check({name, "_released"}, rel_viol, 0);
    end else begin
      check({name, "_frame_bits"}, got, exp);
    end
  endtask

  task automatic abort_read();
    int   t, my_falls;
    logic prev_sclk;
    t = 0; my_falls = 0; prev_sclk = 1'b0;
    repeat (3) @(negedge in_clk);
    in_r_w = 1'b1; in_addr = 9'($urandom); in_wr_data = '0; slave_resp = 16'($urandom);
    in_start = 1'b1;
    while (my_falls < 15 && t < 2000) begin
      @(negedge in_clk);
      t++;
      if (t == 2) in_start = 1'b0;
      if (prev_sclk && !out_tw_clock) my_falls++;
      prev_sclk = out_tw_clock;
    end
    check("abort_reached_data", {31'd0, out_io_in_progress}, 1);
    frames++;
    in_rst = 1'b1;
    #1;
    exp_rd = '0;
    check("abort_cs", out_tw_cs, 1'b1);
    check("abort_sclk", out_tw_clock, 1'b0);
    check("abort_busy", out_io_in_progress, 1'b0);
    check("abort_rd_data", out_rd_data, exp_rd);
    check("abort_line", io_tw_data, 1'b1);
    repeat (3) @(negedge in_clk);
    in_rst = 1'b0;
  endtask

  initial begin
    #100;
    check("reset_cs", out_tw_cs, 1'b1);
    check("reset_sclk", out_tw_clock, 1'b0);
    check("reset_line", io_tw_data, 1'b1);
    check("reset_busy", out_io_in_progress, 1'b0);
    check("reset_rd_data", out_rd_data, 16'h0000);
    @(negedge in_clk);
    in_rst = 1'b0;

    run_frame("write", 1'b0, 9'h155, 16'h00AA, 16'h0000, 1, 1'b0, 2);
    run_frame("read", 1'b1, 9'h0A3, 16'h0000, 16'hBEEF, 1, 1'b0, 2);
    run_frame("hygiene", 1'b0, 9'h0F0, 16'h1234, 16'h0000, 11, 1'b1, 3);
    run_frame("b2b", 1'b1, 9'h1FF, 16'h0000, 16'h5A5A, 3, 1'b0, 2);
    for (int k = 0; k < 6; k++) begin
      logic rw;
      rw = 1'($urandom_range(0, 1));
      run_frame("rnd", rw, 9'($urandom), rw ? 16'h0000 : 16'($urandom), 16'($urandom),
                $urandom_range(1, 12), 1'($urandom_range(0, 1)), $urandom_range(2, 6));
    end
    abort_read();
    run_frame("post_abort", 1'b0, 9'h0C3, 16'hF00F, 16'h0000, 2, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
